mic_useq: RTL

Parametrised microsequencer for the Mic-1 style datapath. It computes the next MPC from the current MIR next-address fields, the registered N/Z flags and MBR. It adds a hardware microsubroutine call/return stack, a stall input for memory wait states and sticky error flags. The block sits between the control store (it drives the control-store address) and the datapath (flags, MBR).

---
 rtl/mic_pkg.sv | 17 +
 rtl/mic_ustack.sv | 53 +++++
 rtl/mic_useq.sv | 103 ++++++++++
 3 files changed

// File: rtl/mic_pkg.sv
// Shared widths, reset address and MIR sequencing-field layout for the Mic-1 microsequencer.
package mic_pkg;

    localparam int MIC_ADDR_W     = 9;
    localparam int MIC_MBR_W      = 8;
    localparam int MIC_RESET_ADDR = 0;

    typedef struct packed {
        logic [MIC_ADDR_W-1:0] next_addr;
        logic                  jmpc;
        logic                  jamn;
        logic                  jamz;
        logic                  call;
        logic                  ret;
    } mir_seq_t;

endpackage

// File: rtl/mic_ustack.sv
// Microsubroutine return-address stack: LIFO, non-wrapping, frozen while hold is high.
module mic_ustack #(
    parameter int ADDR_W      = 9,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [DEPTH_W-1:0] depth,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0]  mem [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   wr_idx;

    assign full    = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty   = (depth_q == '0);
    assign top_idx = IDX_W'(depth_q - 1'b1);
    assign wr_idx  = IDX_W'(depth_q);
    assign top     = mem[top_idx];
    assign depth   = depth_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else if (!hold) begin
            if (pop && !empty) begin
                depth_q <= depth_q - 1'b1;
            end else if (push && !full) begin
                depth_q <= depth_q + 1'b1;
            end
        end
    end

    // NOTE: the storage array is not reset; depth alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && !hold && push && !pop && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/mic_useq.sv
// Mic-1 microsequencer: next-MPC selection with jam/jmpc, call/return stack and sticky error flags.
module mic_useq
    import mic_pkg::*;
#(
    parameter int ADDR_W      = MIC_ADDR_W,
    parameter int MBR_W       = MIC_MBR_W,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               n_in,
    input  logic               z_in,
    input  logic               flag_we,
    input  logic [MBR_W-1:0]   mbr,
    input  logic [ADDR_W-1:0]  next_addr,
    input  logic               jmpc,
    input  logic               jamn,
    input  logic               jamz,
    input  logic               call,
    input  logic [ADDR_W-1:0]  call_target,
    input  logic               ret,
    output logic [ADDR_W-1:0]  mpc,
    output logic [DEPTH_W-1:0] depth,
    output logic               ovf,
    output logic               unf,
    output logic               illegal
);

    logic              n_s, z_s;
    logic              hb;
    logic [ADDR_W-2:0] low;
    logic [ADDR_W-1:0] normal_addr;
    logic [ADDR_W-1:0] mpc_d;
    logic [ADDR_W-1:0] stack_top;
    logic              stack_full, stack_empty;
    logic              do_push, do_pop;
    logic              ovf_set, unf_set, illegal_set;

    // Jam bits always see the flags registered by the previous instruction.
    assign hb          = next_addr[ADDR_W-1] | (jamn & n_s) | (jamz & z_s);
    assign low         = next_addr[ADDR_W-2:0] | (jmpc ? (ADDR_W-1)'(mbr) : '0);
    assign normal_addr = {hb, low};

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        mpc_d       = normal_addr;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        illegal_set = 1'b0;
        if (ret) begin
            do_pop      = !stack_empty;
            unf_set     = stack_empty;
            illegal_set = call;
            mpc_d       = stack_empty ? ADDR_W'(MIC_RESET_ADDR) : stack_top;
        end else if (call) begin
            do_push = !stack_full;
            ovf_set = stack_full;
            mpc_d   = call_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mpc     <= ADDR_W'(MIC_RESET_ADDR);
            n_s     <= 1'b0;
            z_s     <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            illegal <= 1'b0;
        end else if (!stall) begin
            mpc     <= mpc_d;
            ovf     <= ovf | ovf_set;
            unf     <= unf | unf_set;
            illegal <= illegal | illegal_set;
            if (flag_we) begin
                n_s <= n_in;
                z_s <= z_in;
            end
        end
    end

    mic_ustack #(
        .ADDR_W     (ADDR_W),
        .STACK_DEPTH(STACK_DEPTH),
        .DEPTH_W    (DEPTH_W)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .hold     (stall),
        .push     (do_push),
        .pop      (do_pop),
        .push_data(normal_addr),
        .top      (stack_top),
        .depth    (depth),
        .full     (stack_full),
        .empty    (stack_empty)
    );

endmodule
